addr_gen_unit: RTL

//  Parametrised, registered successor to the address select stage.
//  - Picks the memory address from: direct addr, alu_result, or indexed addr+alu_result.
//  - Can also generate a strided burst of addresses.
//  - Drives the memory port through a valid/ready handshake.
//  - Sits between the decode/ALU stage and the data-memory interface.

---
 rtl/addr_gen_unit_pkg.sv | 14 +
 rtl/addr_gen_unit_addr_calc.sv | 24 ++
 rtl/addr_gen_unit.sv | 98 +++++++++
 3 files changed

// File: rtl/addr_gen_unit_pkg.sv
// Shared definitions for the address generation unit: request modes and FSM states.
package addr_gen_unit_pkg;

  localparam logic [1:0] MODE_DIRECT  = 2'b00;
  localparam logic [1:0] MODE_REG     = 2'b01;
  localparam logic [1:0] MODE_INDEXED = 2'b10;
  localparam logic [1:0] MODE_BURST   = 2'b11;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

endpackage

// File: rtl/addr_gen_unit_addr_calc.sv
// Start-address select for a new request; the INDEXED sum wraps modulo 2^AW.
module addr_calc
  import addr_gen_unit_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] alu_result,
  output logic [AW-1:0] start_addr
);

  always_comb begin
    start_addr = addr;
    case (mode)
      MODE_DIRECT:  start_addr = addr;
      MODE_REG:     start_addr = alu_result;
      MODE_INDEXED: start_addr = addr + alu_result;
      MODE_BURST:   start_addr = addr;
      default:      start_addr = addr;
    endcase
  end

endmodule

// File: rtl/addr_gen_unit.sv
// Registered address generator: single-beat and strided-burst addresses
// presented to memory over a valid/ready handshake.
module addr_gen_unit
  import addr_gen_unit_pkg::*;
#(
  parameter int AW = 16,
  parameter int LW = 8,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    mode,
  input  logic [AW-1:0] addr,
  input  logic [AW-1:0] alu_result,
  input  logic [LW-1:0] burst_len,
  input  logic [SW-1:0] stride,
  output logic [AW-1:0] mem_addr,
  output logic          mem_valid,
  output logic          mem_last,
  input  logic          mem_ready,
  output logic          busy
);

  // Handshake: a request is taken when req_valid && req_ready at posedge;
  // a beat completes when mem_valid && mem_ready at posedge. Outputs hold
  // stable while mem_valid && !mem_ready.

  state_t        state;
  logic [LW-1:0] count;
  logic [SW-1:0] stride_q;
  logic [AW-1:0] start_addr;
  logic [LW-1:0] len_m1;
  logic          accept;
  logic          beat_done;

  addr_calc #(.AW(AW)) u_calc (
    .mode       (mode),
    .addr       (addr),
    .alu_result (alu_result),
    .start_addr (start_addr)
  );

  // busy is the FSM state made visible: 1 exactly in ST_BURST.
  assign busy      = (state == ST_BURST);
  assign req_ready = (state == ST_IDLE) && (!mem_valid || mem_ready);
  assign accept    = req_valid && req_ready;
  assign beat_done = mem_valid && mem_ready;
  // A zero length counts as one beat, so the remaining-beat count is clamped at 0.
  assign len_m1    = (burst_len == '0) ? '0 : burst_len - LW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      mem_addr  <= '0;
      mem_valid <= 1'b0;
      mem_last  <= 1'b0;
      count     <= '0;
      stride_q  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            mem_addr  <= start_addr;
            mem_valid <= 1'b1;
            if (mode == MODE_BURST && len_m1 != '0) begin
              state    <= ST_BURST;
              count    <= len_m1;
              stride_q <= stride;
              mem_last <= 1'b0;
            end else begin
              mem_last <= 1'b1;
            end
          end else if (beat_done) begin
            mem_valid <= 1'b0;
            mem_last  <= 1'b0;
          end
        end
        ST_BURST: begin
          if (beat_done) begin
            if (mem_last) begin
              state     <= ST_IDLE;
              mem_valid <= 1'b0;
              mem_last  <= 1'b0;
            end else begin
              mem_addr <= mem_addr + {{(AW-SW){1'b0}}, stride_q};
              count    <= count - LW'(1);
              mem_last <= (count == LW'(1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
